// File: rtl/serv_fetch_buf_if.sv
// Bundle for serv_fetch_buf: core instruction-bus side, decoder taps and Wishbone memory side.
// slave is the fetch buffer's own view; master is the environment (core + memory) view.
interface serv_fetch_buf_if;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [29:0] o_dec_rdt;
  logic        o_dec_en;
  logic [31:0] o_wb_adr;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_wb_rdt, i_wb_ack,
    output o_ibus_rdt, o_ibus_ack, o_dec_rdt, o_dec_en, o_wb_adr, o_wb_cyc
  );

  modport master (
    output i_ibus_adr, i_ibus_cyc, i_wb_rdt, i_wb_ack,
    input  o_ibus_rdt, o_ibus_ack, o_dec_rdt, o_dec_en, o_wb_adr, o_wb_cyc
  );
endinterface

// File: rtl/serv_fetch_buf.sv
// Instruction-fetch front end: serves core fetches from Wishbone memory and, with PREFETCH,
// speculatively fetches the next sequential word into a one-entry buffer.
module serv_fetch_buf #(
  parameter bit PREFETCH = 1'b1
) (
  input logic           clk,
  input logic           i_rst,
  serv_fetch_buf_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DEMAND,
    SPEC,
    SPEC_HIT,
    SPEC_MISS
  } state_t;

  state_t      state;
  logic        buf_valid;
  logic [29:0] buf_tag;
  logic [31:0] buf_data;
  logic        spec_pending;
  logic [29:0] next_adr;

  logic        req;
  logic        adr_match;
  logic        buf_hit;
  logic        wb_deliver;
  logic [1:0]  unused_adr_lsb;

  assign unused_adr_lsb = bus.i_ibus_adr[1:0];

  // The acknowledge cycle never starts a new request, even though the core still holds cyc.
  assign req        = bus.i_ibus_cyc & ~bus.o_ibus_ack;
  assign adr_match  = bus.i_ibus_adr[31:2] == bus.o_wb_adr[31:2];
  assign buf_hit    = PREFETCH & buf_valid & (buf_tag == bus.i_ibus_adr[31:2]);
  assign wb_deliver = bus.i_wb_ack & ((state == DEMAND) || (state == SPEC_HIT) ||
                                      ((state == SPEC) && req && adr_match));

  assign bus.o_dec_rdt = bus.o_ibus_rdt[31:2];
  assign bus.o_dec_en  = bus.o_ibus_ack;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      buf_valid      <= 1'b0;
      buf_tag        <= '0;
      buf_data       <= '0;
      spec_pending   <= 1'b0;
      next_adr       <= '0;
      bus.o_ibus_rdt <= '0;
      bus.o_ibus_ack <= 1'b0;
      bus.o_wb_adr   <= '0;
      bus.o_wb_cyc   <= 1'b0;
    end else begin
      bus.o_ibus_ack <= 1'b0;
      if (wb_deliver) begin
        // Demand completion and matching-prefetch completion share one path.
        bus.o_ibus_rdt <= bus.i_wb_rdt;
        bus.o_ibus_ack <= 1'b1;
        bus.o_wb_cyc   <= 1'b0;
        next_adr       <= bus.o_wb_adr[31:2] + 30'd1;
        spec_pending   <= PREFETCH;
        state          <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (req) begin
              buf_valid <= 1'b0;
              if (buf_hit) begin
                bus.o_ibus_rdt <= buf_data;
                bus.o_ibus_ack <= 1'b1;
                next_adr       <= buf_tag + 30'd1;
                spec_pending   <= PREFETCH;
              end else begin
                spec_pending <= 1'b0;
                bus.o_wb_adr <= {bus.i_ibus_adr[31:2], 2'b00};
                bus.o_wb_cyc <= 1'b1;
                state        <= DEMAND;
              end
            end else if (spec_pending) begin
              bus.o_wb_adr <= {next_adr, 2'b00};
              bus.o_wb_cyc <= 1'b1;
              spec_pending <= 1'b0;
              state        <= SPEC;
            end
          end
          DEMAND, SPEC_HIT: ;
          SPEC: begin
            if (bus.i_wb_ack) begin
              bus.o_wb_cyc <= 1'b0;
              state        <= IDLE;
              if (!req) begin
                buf_data  <= bus.i_wb_rdt;
                buf_tag   <= bus.o_wb_adr[31:2];
                buf_valid <= PREFETCH;
              end
            end else if (req) begin
              state <= adr_match ? SPEC_HIT : SPEC_MISS;
            end
          end
          // Mismatched prefetch: data dropped, IDLE re-accepts the held request one cycle later.
          SPEC_MISS: begin
            if (bus.i_wb_ack) begin
              bus.o_wb_cyc <= 1'b0;
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serv_fetch_buf.sv
// Bench for serv_fetch_buf: vector table of core fetches against a latency-3 memory model,
// plus hand-written reset-abort and PREFETCH=0 sequences.
module tb_serv_fetch_buf;

  localparam int unsigned MEM_LAT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serv_fetch_buf_if bus ();
  serv_fetch_buf_if bus0 ();

  serv_fetch_buf #(.PREFETCH(1'b1)) dut (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  serv_fetch_buf #(.PREFETCH(1'b0)) dut0 (
    .clk   (clk),
    .i_rst (rst),
    .bus   (bus0)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] mem_data(logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_0104: return 32'h0010_8113;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory model: ack after MEM_LAT cycles of cyc; manual mode acks on request from the main block.
  logic        mem_en;
  logic [31:0] man_rdt;
  int unsigned man_req;
  int unsigned man_done;
  int unsigned mem_cnt;

  initial begin
    bus.i_wb_ack = 1'b0;
    bus.i_wb_rdt = '0;
    mem_cnt      = 0;
    man_done     = 0;
    forever begin
      @(posedge clk); #1;
      if (!mem_en) begin
        mem_cnt = 0;
        if (man_req != man_done) begin
          bus.i_wb_ack = 1'b1;
          bus.i_wb_rdt = man_rdt;
          man_done     = man_req;
        end else begin
          bus.i_wb_ack = 1'b0;
        end
      end else if (bus.i_wb_ack) begin
        bus.i_wb_ack = 1'b0;
        mem_cnt      = 0;
      end else if (bus.o_wb_cyc) begin
        mem_cnt++;
        if (mem_cnt >= MEM_LAT) begin
          bus.i_wb_ack = 1'b1;
          bus.i_wb_rdt = mem_data(bus.o_wb_adr);
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Monitor: Wishbone cycle start addresses, address stability, core ack pulse count.
  logic [31:0] wb_log[$];
  int unsigned ack_pulses;
  int unsigned adr_changes;
  logic        prev_cyc;
  logic [31:0] prev_adr;

  initial begin
    ack_pulses  = 0;
    adr_changes = 0;
    prev_cyc    = 1'b0;
    prev_adr    = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.o_wb_cyc && !prev_cyc) wb_log.push_back(bus.o_wb_adr);
      if (bus.o_wb_cyc && prev_cyc && (bus.o_wb_adr != prev_adr)) adr_changes++;
      if (bus.o_ibus_ack) ack_pulses++;
      prev_cyc = bus.o_wb_cyc;
      prev_adr = bus.o_wb_adr;
    end
  end

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic fetch(input logic [31:0] adr, input int unsigned exp_lat, input string name);
    exp_t        e;
    int unsigned n;
    e.adr  = adr;
    e.data = mem_data(adr);
    sb.push_back(e);
    bus.i_ibus_adr = adr;
    bus.i_ibus_cyc = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.o_ibus_ack && n < 40);
    bus.i_ibus_cyc = 1'b0;
    e = sb.pop_front();
    check({name, "_ack"}, 32'(bus.o_ibus_ack), 32'd1);
    check({name, "_lat"}, n, exp_lat);
    check({name, "_rdt"}, bus.o_ibus_rdt, e.data);
    check({name, "_dec_rdt"}, 32'(bus.o_dec_rdt), e.data >> 2);
    check({name, "_dec_en"}, 32'(bus.o_dec_en), 32'd1);
    @(posedge clk); #1;
    check({name, "_ack_pulse"}, 32'(bus.o_ibus_ack), 32'd0);
  endtask

  typedef struct {
    logic [31:0] adr;
    int unsigned gap;
    int unsigned lat;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] exp_log[10];
  int unsigned hi_cnt;

  initial begin
    // cold miss, buffered hit, mid-prefetch match, same-cycle match, jump, wrap miss, wrap hit
    vecs[0] = '{32'h0000_0100, 0, 4};
    vecs[1] = '{32'h0000_0104, 6, 1};
    vecs[2] = '{32'h0000_0108, 0, 3};
    vecs[3] = '{32'h0000_010C, 2, 1};
    vecs[4] = '{32'h0000_0200, 0, 7};
    vecs[5] = '{32'hFFFF_FFFC, 5, 4};
    vecs[6] = '{32'h0000_0000, 6, 1};
    exp_log = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110,
                32'h200, 32'h204, 32'hFFFF_FFFC, 32'h0, 32'h4};

    rst             = 1'b1;
    mem_en          = 1'b1;
    man_req         = 0;
    man_rdt         = '0;
    bus.i_ibus_adr  = '0;
    bus.i_ibus_cyc  = 1'b0;
    bus0.i_ibus_adr = '0;
    bus0.i_ibus_cyc = 1'b0;
    bus0.i_wb_ack   = 1'b0;
    bus0.i_wb_rdt   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_cyc", 32'(bus.o_wb_cyc), 32'd0);
    check("rst_wb_adr", bus.o_wb_adr, 32'd0);
    check("rst_ibus_ack", 32'(bus.o_ibus_ack), 32'd0);
    check("rst_ibus_rdt", bus.o_ibus_rdt, 32'd0);
    check("rst_dec_en", 32'(bus.o_dec_en), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      repeat (vecs[i].gap) begin
        @(posedge clk); #1;
      end
      fetch(vecs[i].adr, vecs[i].lat, $sformatf("v%0d", i));
    end
    repeat (8) begin
      @(posedge clk); #1;
    end

    check("wb_log_size", wb_log.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < wb_log.size()) check($sformatf("wb_log%0d", i), wb_log[i], exp_log[i]);
    end
    check("wb_adr_stable", adr_changes, 32'd0);
    check("ack_pulses", ack_pulses, 32'd7);

    // Reset while a demand fetch is in flight; the late memory ack must be ignored.
    mem_en         = 1'b0;
    bus.i_ibus_adr = 32'h0000_0300;
    bus.i_ibus_cyc = 1'b1;
    @(posedge clk); #1;
    check("abort_wb_cyc", 32'(bus.o_wb_cyc), 32'd1);
    check("abort_wb_adr", bus.o_wb_adr, 32'h0000_0300);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_wb_cyc", 32'(bus.o_wb_cyc), 32'd0);
    check("async_wb_adr", bus.o_wb_adr, 32'd0);
    check("async_ibus_ack", 32'(bus.o_ibus_ack), 32'd0);
    check("async_ibus_rdt", bus.o_ibus_rdt, 32'd0);
    check("async_dec_rdt", 32'(bus.o_dec_rdt), 32'd0);
    #1;
    rst            = 1'b0;
    bus.i_ibus_cyc = 1'b0;
    man_rdt        = 32'hDEAD_BEEF;
    man_req++;
    hi_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.o_ibus_ack || bus.o_wb_cyc) hi_cnt++;
    end
    check("late_ack_ignored", hi_cnt, 32'd0);
    check("late_ack_pulses", ack_pulses, 32'd7);

    // PREFETCH=0 instance: plain miss path, no speculative cycle afterwards.
    for (int i = 0; i < 2; i++) begin
      bus0.i_ibus_adr = 32'h0000_0100 + 32'(i * 4);
      bus0.i_ibus_cyc = 1'b1;
      @(posedge clk); #1;
      check($sformatf("np%0d_wb_cyc", i), 32'(bus0.o_wb_cyc), 32'd1);
      check($sformatf("np%0d_wb_adr", i), bus0.o_wb_adr, bus0.i_ibus_adr);
      bus0.i_wb_ack = 1'b1;
      bus0.i_wb_rdt = mem_data(bus0.i_ibus_adr);
      @(posedge clk); #1;
      bus0.i_wb_ack   = 1'b0;
      bus0.i_ibus_cyc = 1'b0;
      check($sformatf("np%0d_ack", i), 32'(bus0.o_ibus_ack), 32'd1);
      check($sformatf("np%0d_rdt", i), bus0.o_ibus_rdt, mem_data(bus0.i_ibus_adr));
      check($sformatf("np%0d_cyc_drop", i), 32'(bus0.o_wb_cyc), 32'd0);
      hi_cnt = 0;
      repeat (6) begin
        @(posedge clk); #1;
        if (bus0.o_wb_cyc || bus0.o_ibus_ack) hi_cnt++;
      end
      check($sformatf("np%0d_no_spec", i), hi_cnt, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
